// File: rtl/line_window_buffer.sv
// Streaming 3-row vertical window: each accepted pixel leaves with the pixels
// directly above it from the two previous lines, using two single-line RAMs.

module line_window_buffer_ram #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16,
  parameter int AW_P    = 4
) (
  input  logic               clk_i,
  input  logic               rd_en_i,
  input  logic               wr_en_i,
  input  logic [AW_P-1:0]    addr_i,
  input  logic [WIDTH_P-1:0] wdata_i,
  output logic [WIDTH_P-1:0] rdata_o
);
  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [WIDTH_P-1:0] rdata_q;

  // Read-before-write: a same-address access returns the previous contents.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
endmodule

module line_window_buffer #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH_P-1:0]   data_i,
  input  logic                 sof_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [3*WIDTH_P-1:0] data_o,
  output logic                 eol_o
);
  localparam int CW = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W_P - 1);

  logic [CW-1:0]      col_q, col_d, col_eff;
  logic [1:0]         rows_q, rows_d, rows_eff;
  logic               sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               eol_q, eol_d;
  logic               accept;
  logic               wrap;
  logic               top_sel_q;
  logic [WIDTH_P-1:0] pix_q;
  logic [WIDTH_P-1:0] rd0, rd1;

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // A start-of-frame pixel restarts the counters at (0,0) but keeps sel.
  always_comb begin
    col_eff  = sof_i ? '0 : col_q;
    rows_eff = sof_i ? 2'd0 : rows_q;
    wrap     = (col_eff == LAST_COL);
    col_d    = col_q;
    rows_d   = rows_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    eol_d    = eol_q;
    if (accept) begin
      col_d   = wrap ? '0 : col_eff + CW'(1);
      rows_d  = (wrap && rows_eff != 2'd2) ? rows_eff + 2'd1 : rows_eff;
      sel_d   = wrap ? ~sel_q : sel_q;
      valid_d = (rows_eff == 2'd2);
      eol_d   = wrap;
    end else if (ready_i) begin
      valid_d = 1'b0;
      eol_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q   <= '0;
      rows_q  <= 2'd0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      rows_q  <= rows_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
    end
  end

  // RAM[sel] holds row y-2: it is read for the top tap and overwritten with row y.
  line_window_buffer_ram #(
    .WIDTH_P(WIDTH_P),
    .DEPTH_P(LINE_W_P),
    .AW_P   (CW)
  ) u_ram0 (
    .clk_i  (clk_i),
    .rd_en_i(accept),
    .wr_en_i(accept & ~sel_q),
    .addr_i (col_eff),
    .wdata_i(data_i),
    .rdata_o(rd0)
  );

  line_window_buffer_ram #(
    .WIDTH_P(WIDTH_P),
    .DEPTH_P(LINE_W_P),
    .AW_P   (CW)
  ) u_ram1 (
    .clk_i  (clk_i),
    .rd_en_i(accept),
    .wr_en_i(accept & sel_q),
    .addr_i (col_eff),
    .wdata_i(data_i),
    .rdata_o(rd1)
  );

  // sel may toggle on the accepting edge, so the output mux uses its registered copy.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pix_q     <= data_i;
      top_sel_q <= sel_q;
    end
  end

  assign valid_o = valid_q;
  assign eol_o   = eol_q;
  assign data_o  = {(top_sel_q ? rd1 : rd0), (top_sel_q ? rd0 : rd1), pix_q};
endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, pixel width in bits.
REQ-002 SHALL have parameter LINE_W_P, default 16, pixels per line (>=2).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port valid_i, input, 1, input pixel valid.
REQ-006 SHALL have port ready_o, output, 1, block can accept a pixel.
REQ-007 SHALL have port data_i, input, WIDTH_P, input pixel in raster order.
REQ-008 SHALL have port sof_i, input, 1, start of frame; sampled with data_i.
REQ-009 SHALL have port valid_o, output, 1, output column valid.
REQ-010 SHALL have port ready_i, input, 1, downstream accepts the column.
REQ-011 SHALL have port data_o, output, 3*WIDTH_P, column as {top (row y-2), mid (row y-1), bot (row y)}, with top in the MSBs.
REQ-012 SHALL have port eol_o, output, 1, output column is the last column of its line.

Function
REQ-013 SHALL treat an input transfer as accepted on any edge with valid_i=1 and ready_o=1.
REQ-014 SHALL drive ready_o = ~valid_o | ready_i, combinationally, with no other stall source.
REQ-015 SHALL store the two previous lines in two internal synchronous RAMs of depth LINE_W_P. These RAMs have 1-cycle read latency, return old data on a same-address read/write, and hold data_o when not reading.
REQ-016 SHALL keep a column counter col (0..LINE_W_P-1) that wraps to 0 after LINE_W_P-1 on accept.
REQ-017 SHALL keep a row counter rows that increments on each wrap and saturates at 2.
REQ-018 SHALL keep a 1-bit selector sel that toggles on each wrap; RAM[sel] holds row y-2 and RAM[~sel] holds row y-1.
REQ-019 On accept at column c, SHALL read both RAMs at address c and write data_i into RAM[sel] at address c in the same cycle.
REQ-020 An accept with sof_i=1 SHALL be treated as col=0, rows=0; the counters then advance from that point, and sel is left unchanged.
REQ-021 Latency SHALL be 1 cycle: a column appears on data_o on the edge after its accept, with top = old RAM[sel][c], mid = RAM[~sel][c], and bot = registered pixel.
REQ-022 SHALL set valid_o on the edge after an accept only if rows==2 at accept time; pixels of the first two lines of a frame SHALL be stored but produce no output.
REQ-023 SHALL clear valid_o on an edge with ready_i=1 and no qualifying accept.
REQ-024 While valid_o=1 and ready_i=0, data_o and eol_o SHALL be held stable and no RAM read or write SHALL occur.
REQ-025 eol_o SHALL be 1 exactly when the output column came from col==LINE_W_P-1; eol_o is registered alongside valid_o.
REQ-026 Back-to-back accepts with valid_o=1 and ready_i=1 SHALL sustain 1 column per cycle without bubbles.

Reset
REQ-027 While rst_i=1, SHALL force valid_o=0, eol_o=0, col=0, rows=0, sel=0 asynchronously; ready_o therefore reads 1.
REQ-028 SHALL NOT clear RAM contents on reset; stale data is masked by rows.
REQ-029 Reset asserted mid-line SHALL drop any pending output column; the first post-reset pixel is col 0, row 0.

Verification (LINE_W_P=4, WIDTH_P=8)
REQ-030 Fill: stream rows with pixel = 16*row + col for rows 0..3, ready_i=1. Required: no valid_o during rows 0-1. Row 2 col 1 outputs {0x01,0x11,0x21}. Row 3 col 3 outputs {0x13,0x23,0x33} with eol_o=1.
REQ-031 Backpressure: hold ready_i=0 for 5 cycles mid-row 2. Required: ready_o=0 and data_o held stable throughout; the stream resumes with no lost or duplicated column.
REQ-032 Throughput: continuous valid_i with ready_i=1 during rows 2-3. Required: 8 consecutive valid_o cycles at 1 column per cycle.
REQ-033 SOF restart: assert sof_i on row 2 col 2. Required: no valid_o for the next 8 accepts; row 2 of the new frame then outputs new-frame data only.
REQ-034 Reset mid-row 3: assert rst_i for 2 cycles. Required: valid_o=0 immediately; the first 8 post-reset pixels produce no output.
REQ-035 Random: 1000 pixels with random valid_i/ready_i and a scoreboard model. Required: every column matches {y-2, y-1, y} at the same column, with eol_o correct.
